// File: rtl/regfile_sb_pkg.sv
// regfile_pkg: shared defaults and scoreboard types for regfile_sb.
// Optional same-cycle forwarding is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NRD = 3;
  localparam int DEF_PC_IDX = 15;
  localparam int DEF_PC_OFFSET = 8;
  typedef logic [1:0] pend_cnt_t;
  localparam pend_cnt_t PEND_MAX = 2'd3;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: writeback, issue and read-port bundle of the register file.
interface regfile_sb_if #(
  parameter int DATA_W = regfile_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_pkg::DEF_ADDR_W,
  parameter int NRD = regfile_pkg::DEF_NRD
);
  logic we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD*DATA_W-1:0] rd;
  logic [DATA_W-1:0] pc;
  logic iss;
  logic [ADDR_W-1:0] iss_dst;
  logic [NRD-1:0] busy;
  logic stall;
  logic err;
  modport master(output we, wa, wd, ra, pc, iss, iss_dst, input rd, busy, stall, err);
  modport slave(input we, wa, wd, ra, pc, iss, iss_dst, output rd, busy, stall, err);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters, overflow flag and busy/stall.
// Under REGFILE_BYPASS_EN, busy drops for the last pending write landing this cycle.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD = DEF_NRD
) (
  input  logic clk,
  input  logic rst,
  input  logic iss,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD-1:0] busy,
  output logic stall,
  output logic err
);
  localparam int NREGS = 2**ADDR_W;
  pend_cnt_t cnt [NREGS];
  for (genvar r = 0; r < NREGS; r++) begin : g_cnt
    pend_cnt_t q;
    logic inc, dec;
    assign inc = iss && iss_dst == ADDR_W'(r);
    assign dec = we && wa == ADDR_W'(r);
    assign cnt[r] = q;
    always_ff @(posedge clk or negedge rst)
      if (!rst) q <= '0;
      else if (inc && !dec && q != PEND_MAX) q <= q + 2'd1;
      else if (dec && !inc && q != '0) q <= q - 2'd1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if (iss && !(we && wa == iss_dst) && cnt[iss_dst] == PEND_MAX) err <= 1'b1;
  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic [ADDR_W-1:0] a;
    assign a = ra[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign busy[i] = cnt[a] != '0 && !(we && wa == a && cnt[a] == 2'd1);
`else
    assign busy[i] = cnt[a] != '0;
`endif
  end
  assign stall = |busy;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with PC-sourced index and pending-write scoreboard.
// REGFILE_BYPASS_EN adds same-cycle writeback forwarding on the read ports.
module regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD = DEF_NRD,
  parameter int PC_IDX = DEF_PC_IDX,
  parameter int PC_OFFSET = DEF_PC_OFFSET
) (
  input logic clk,
  input logic rst,
  regfile_sb_if.slave bus
);
  localparam int NREGS = 2**ADDR_W;
  logic [DATA_W-1:0] regs [NREGS];
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == PC_IDX) begin : g_pc
      assign regs[r] = '0;
    end else begin : g_st
      logic [DATA_W-1:0] q;
      assign regs[r] = q;
      always_ff @(posedge clk or negedge rst)
        if (!rst) q <= '0;
        else if (bus.we && bus.wa == ADDR_W'(r)) q <= bus.wd;
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = bus.ra[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign bus.rd[i*DATA_W +: DATA_W] = a == ADDR_W'(PC_IDX) ? bus.pc + DATA_W'(PC_OFFSET)
                                      : bus.we && bus.wa == a ? bus.wd : regs[a];
`else
    assign bus.rd[i*DATA_W +: DATA_W] = a == ADDR_W'(PC_IDX) ? bus.pc + DATA_W'(PC_OFFSET) : regs[a];
`endif
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NRD(NRD)) u_sb (
    .clk(clk),
    .rst(rst),
    .iss(bus.iss),
    .iss_dst(bus.iss_dst),
    .we(bus.we),
    .wa(bus.wa),
    .ra(bus.ra),
    .busy(bus.busy),
    .stall(bus.stall),
    .err(bus.err)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table, hand sequences for bypass/reset, then random traffic vs a reference model.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  regfile_sb_if #(.DATA_W(32), .ADDR_W(4), .NRD(3)) bus();
  regfile_sb dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic we; logic [3:0] wa; logic [31:0] wd;
    logic iss; logic [3:0] dst;
    logic [3:0] r0, r1, r2; logic [31:0] pc;
    logic [31:0] e0, e1, e2; logic [2:0] eb; logic ee;
  } vec_t;
  vec_t tbl [25];
  logic [31:0] mreg [16];
  int mcnt [16];
  bit merr;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  function automatic vec_t mk(logic we, logic [3:0] wa, logic [31:0] wd, logic iss, logic [3:0] dst,
                              logic [3:0] r0, logic [3:0] r1, logic [3:0] r2, logic [31:0] pc,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic [2:0] eb, logic ee);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.iss = iss; v.dst = dst;
    v.r0 = r0; v.r1 = r1; v.r2 = r2; v.pc = pc;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.eb = eb; v.ee = ee;
    return v;
  endfunction
  task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic drv(input logic we, input logic [3:0] wa, input logic [31:0] wd, input logic iss,
                     input logic [3:0] dst, input logic [3:0] r0, input logic [3:0] r1,
                     input logic [3:0] r2, input logic [31:0] pc);
    bus.we = we; bus.wa = wa; bus.wd = wd; bus.iss = iss; bus.iss_dst = dst;
    bus.ra = {r2, r1, r0}; bus.pc = pc;
  endtask
  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin mreg[r] = '0; mcnt[r] = 0; end
    merr = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk);
    if (bus.we && bus.wa != 4'd15) mreg[bus.wa] = bus.wd;
    if (!(bus.iss && bus.we && bus.iss_dst == bus.wa)) begin
      if (bus.iss) begin
        if (mcnt[bus.iss_dst] == 3) merr = 1'b1;
        else mcnt[bus.iss_dst]++;
      end
      if (bus.we && mcnt[bus.wa] > 0) mcnt[bus.wa]--;
    end
    #1;
  endtask
  function automatic logic [31:0] erd(logic [3:0] a);
    if (a == 4'd15) return bus.pc + 32'd8;
    if (BYP && bus.we && bus.wa == a) return bus.wd;
    return mreg[a];
  endfunction
  function automatic logic ebusy(logic [3:0] a);
    return mcnt[a] != 0 && !(BYP && bus.we && bus.wa == a && mcnt[a] == 1);
  endfunction
  initial begin
    logic [2:0] eb;
    tbl[0]  = mk(1, 4,   255, 0, 0, 1, 2, 3,   0,   0,     0,   0, 3'b000, 0);
    tbl[1]  = mk(1, 5, 25500, 0, 0, 4, 15, 7, 100, 255,   108,   0, 3'b000, 0);
    tbl[2]  = mk(1, 15,  500, 0, 0, 4, 5, 7,   0, 255, 25500,   0, 3'b000, 0);
    tbl[3]  = mk(0, 0,     0, 0, 0, 15, 5, 4,  0,   8, 25500, 255, 3'b000, 0);
    tbl[4]  = mk(0, 0,     0, 1, 7, 7, 0, 0,   0,   0,     0,   0, 3'b000, 0);
    tbl[5]  = mk(0, 0,     0, 1, 7, 7, 0, 0,   0,   0,     0,   0, 3'b001, 0);
    tbl[6]  = mk(1, 7,    77, 0, 0, 1, 1, 1,   0,   0,     0,   0, 3'b000, 0);
    tbl[7]  = mk(0, 0,     0, 0, 0, 7, 1, 1,   0,  77,     0,   0, 3'b001, 0);
    tbl[8]  = mk(1, 7,    78, 1, 7, 1, 1, 1,   0,   0,     0,   0, 3'b000, 0);
    tbl[9]  = mk(0, 0,     0, 0, 0, 7, 7, 1,   0,  78,    78,   0, 3'b011, 0);
    tbl[10] = mk(1, 7,    79, 0, 0, 1, 1, 1,   0,   0,     0,   0, 3'b000, 0);
    tbl[11] = mk(0, 0,     0, 0, 0, 7, 2, 2,   0,  79,     0,   0, 3'b000, 0);
    for (int k = 12; k < 16; k++) tbl[k] = mk(0, 0, 0, 1, 3, 1, 1, 1, 0, 0, 0, 0, 3'b000, 0);
    tbl[16] = mk(0, 0,     0, 0, 0, 3, 1, 1,   0,   0,     0,   0, 3'b001, 1);
    tbl[17] = mk(1, 3,     3, 0, 0, 1, 1, 1,   0,   0,     0,   0, 3'b000, 1);
    tbl[18] = mk(1, 3,     3, 0, 0, 1, 1, 1,   0,   0,     0,   0, 3'b000, 1);
    tbl[19] = mk(0, 0,     0, 0, 0, 3, 1, 1,   0,   3,     0,   0, 3'b001, 1);
    tbl[20] = mk(1, 3,     3, 0, 0, 1, 1, 1,   0,   0,     0,   0, 3'b000, 1);
    tbl[21] = mk(0, 0,     0, 0, 0, 3, 1, 1,   0,   3,     0,   0, 3'b000, 1);
    tbl[22] = mk(1, 9,     9, 0, 0, 1, 1, 1,   0,   0,     0,   0, 3'b000, 1);
    tbl[23] = mk(0, 0,     0, 1, 9, 9, 1, 1,   0,   9,     0,   0, 3'b000, 1);
    tbl[24] = mk(0, 0,     0, 0, 0, 9, 1, 1,   0,   9,     0,   0, 3'b001, 1);
    model_reset();
    drv(0, 0, 0, 0, 0, 2, 4, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd", bus.rd, '0);
    chk("reset_busy", 96'(bus.busy), 96'(0));
    chk("reset_err", 96'(bus.err), 96'(0));
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 25; k++) begin
      drv(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].iss, tbl[k].dst, tbl[k].r0, tbl[k].r1, tbl[k].r2, tbl[k].pc);
      #1;
      chk($sformatf("vec%0d_rd", k), bus.rd, {tbl[k].e2, tbl[k].e1, tbl[k].e0});
      chk($sformatf("vec%0d_busy", k), 96'(bus.busy), 96'(tbl[k].eb));
      chk($sformatf("vec%0d_stall", k), 96'(bus.stall), 96'(|tbl[k].eb));
      chk($sformatf("vec%0d_err", k), 96'(bus.err), 96'(tbl[k].ee));
      tick();
    end
    drv(0, 0, 0, 1, 7, 1, 1, 1, 0);
    tick();
    drv(1, 7, 500, 0, 0, 7, 1, 1, 0);
    #1;
    chk("byp_rd0", 96'(bus.rd[31:0]), BYP ? 96'(500) : 96'(79));
    chk("byp_busy0", 96'(bus.busy[0]), BYP ? 96'(0) : 96'(1));
    tick();
    drv(0, 0, 0, 0, 0, 7, 1, 1, 0);
    #1;
    chk("byp_after_rd0", 96'(bus.rd[31:0]), 96'(500));
    chk("byp_after_busy0", 96'(bus.busy[0]), 96'(0));
    drv(1, 2, 22, 0, 0, 1, 1, 1, 0);
    tick();
    drv(0, 0, 0, 1, 2, 1, 1, 1, 0);
    tick();
    drv(0, 0, 0, 0, 0, 2, 4, 15, 0);
    #1;
    chk("pre_rst_rd", bus.rd, {32'd8, 32'd255, 32'd22});
    chk("pre_rst_busy", 96'(bus.busy), 96'(3'b001));
    #1 rst = 1'b0;
    #1;
    chk("async_rst_rd", bus.rd, {32'd8, 32'd0, 32'd0});
    chk("async_rst_busy", 96'(bus.busy), 96'(0));
    chk("async_rst_stall", 96'(bus.stall), 96'(0));
    chk("async_rst_err", 96'(bus.err), 96'(0));
    model_reset();
    @(negedge clk) rst = 1'b1;
    for (int n = 0; n < 400; n++) begin
      drv(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 1'($urandom_range(0, 1)), 4'($urandom),
          4'($urandom), 4'($urandom), 4'($urandom), $urandom);
      #1;
      eb = '0;
      for (int i = 0; i < 3; i++) begin
        logic [3:0] a;
        a = bus.ra[i*4 +: 4];
        eb[i] = ebusy(a);
        chk($sformatf("rnd%0d_rd%0d", n, i), 96'(bus.rd[i*32 +: 32]), 96'(erd(a)));
      end
      chk($sformatf("rnd%0d_busy", n), 96'(bus.busy), 96'(eb));
      chk($sformatf("rnd%0d_stall", n), 96'(bus.stall), 96'(|eb));
      chk($sformatf("rnd%0d_err", n), 96'(bus.err), 96'(merr));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with a pending-write scoreboard, the next generation of the processor's 16×32 register file. Sits between decode and writeback of the pipelined reverb datapath. It supplies operands, with R15 sourced from the PC. It tracks in-flight destination registers so decode can stall on RAW hazards.

## Interface
- DATA_W, 32, register width
- ADDR_W, 4, address width; NREGS = 2**ADDR_W
- NRD, 3, number of read ports (1..4)
- PC_IDX, 15, index whose read returns PC + PC_OFFSET
- PC_OFFSET, 8, added to pc on PC_IDX reads (mod 2**DATA_W)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- we  in  1  writeback enable
- wa  in  ADDR_W  writeback address
- wd  in  DATA_W  writeback data
- ra  in  NRD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd  out  NRD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- pc  in  DATA_W  current PC
- iss  in  1  issue: instruction with destination iss_dst enters pipeline
- iss_dst  in  ADDR_W  destination of issued instruction
- busy  out  NRD  port i reads a register with pending writes
- stall  out  1  OR of busy
- err  out  1  sticky pending-counter overflow

## Operation
- Storage: NREGS-1 flops of DATA_W; PC_IDX has no storage. Writes to PC_IDX are dropped but still update the scoreboard.
- Write: on rising clk with we=1 and wa≠PC_IDX, regs[wa] <= wd.
- Read, combinational: rd[i] = pc+PC_OFFSET if ra[i]==PC_IDX, else regs[ra[i]].
- Scoreboard: 2-bit pending counter per register, including PC_IDX.
  - iss alone on reg r: cnt[r]+1.
  - we alone on r: cnt[r]-1; saturates at 0, no error.
  - iss and we on the same r in one cycle: unchanged.
  - iss and we on different regs: both applied.
  - iss with cnt[r]==3 and no simultaneous we to r: counter stays 3, err <= 1.
- busy[i] = (cnt[ra[i]] != 0); stall = |busy.
- err clears only on reset.
- Reset (rst=0, asynchronous): all regs 0, all counters 0, err 0. Hence rd = 0 for non-PC ports, busy=0, stall=0 while in reset.

## Timing
- Read latency 0 (combinational from ra/pc/state).
- Written value visible on rd from the cycle after the write edge, unless bypass is compiled in.
- Scoreboard update takes effect the cycle after the edge; busy is combinational from the counter.
- Reset is asynchronous assert, synchronous-release expected from the top level. Mid-operation reset discards all pending state.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle forwarding.
  - rd[i] = wd when we=1, wa==ra[i] and ra[i]≠PC_IDX.
  - busy[i] is suppressed when we=1, wa==ra[i] and cnt[ra[i]]==1.
- Not defined: no forwarding. rd shows the old value and busy stays asserted until the edge after writeback.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W, PC_IDX and PC_OFFSET constants
  - typedef pend_cnt_t (logic [1:0])
  - PEND_MAX = 2'd3
- Sub-module regfile_scoreboard contains the counters, err, and busy/stall generation.
- regfile_sb contains storage, read muxes, PC path and the bypass.

## Test plan
- Reset: drive rst=0 mid-run after writes. Expect rd=0 for ra=2 and 4, busy=0, err=0 immediately (asynchronous).
- Write/read: we=1, wa=4, wd=255, then wa=5, wd=25500. Next cycle ra={4,5,7} gives rd={255,25500,0}. ra=15 with pc=100 gives 108.
- PC write ignored: we=1, wa=15, wd=500. Then ra=15 with pc=0 gives 8.
- Scoreboard: iss with dst=7 twice, ra0=7. Expect busy[0]=1, stall=1. After the first we to wa=7, busy stays 1. After the second, busy=0. Simultaneous iss+we on 7 leaves the count unchanged.
- Overflow: four iss to reg 3 with no writeback. Expect err=1 after the 4th edge, cnt held at 3. Three writebacks then give busy=0.
- Bypass (REGFILE_BYPASS_EN): with cnt[7]=1, drive we=1, wa=7, wd=500, ra0=7 in the same cycle. Expect rd0=500, busy[0]=0. Without the macro: rd0 shows the old value and busy[0]=1.
